// File: rtl/lc3b_cache_pkg.sv
// Cache types shared by the LC-3b cache slice.
// Contents: line/tag/index/offset types, controller state enum,
// set count, and the byte-masked word merge helper.
package lc3b_types;

  typedef logic [127:0] lc3b_cache_line;
  typedef logic [8:0]   lc3b_cache_tag;
  typedef logic [2:0]   lc3b_cache_index;
  typedef logic [2:0]   lc3b_cache_offset;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    CACHE_IDLE,
    CACHE_RESP,
    CACHE_WRITEBACK,
    CACHE_FILL
  } lc3b_cache_state;

  localparam int unsigned CACHE_SETS = 8;

  // Replace the bytes of word 'off' selected by 'be' with 'wdata'.
  function automatic lc3b_cache_line merge_word(
    input lc3b_cache_line   line,
    input lc3b_cache_offset off,
    input lc3b_word         wdata,
    input logic [1:0]       be
  );
    lc3b_cache_line m;
    m = line;
    if (be[0]) m[{off, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) m[{off, 4'b1000} +: 8] = wdata[15:8];
    return m;
  endfunction

endpackage

// File: rtl/lc3b_cache_array.sv
// cache_array: 8-entry storage array, WIDTH bits per entry.
// Asynchronous combinational read at 'index', synchronous write when 'we'.
// ASYNC_RST=1 clears every entry on rst_n low (valid/dirty bits);
// ASYNC_RST=0 leaves contents unreset (tag/data).
// Ports: clk, rst_n, we, index[2:0], wdata[WIDTH-1:0], rdata[WIDTH-1:0].
module cache_array
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter bit          ASYNC_RST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [2:0]            index,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [CACHE_SETS];

  generate
    if (ASYNC_RST) begin : g_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem <= '{default: '0};
        end else if (we) begin
          mem[index] <= wdata;
        end
      end
    end else begin : g_norst
      logic rst_unused;
      assign rst_unused = rst_n;
      always_ff @(posedge clk) begin
        if (we) mem[index] <= wdata;
      end
    end
  endgenerate

  assign rdata = mem[index];

endmodule

// File: rtl/lc3b_cache.sv
// lc3b_cache: direct-mapped, write-back, write-allocate cache between the
// LC-3b MAR/MDR memory port and 128-bit physical memory.
// CPU side : mem_read, mem_write, mem_byte_enable[1:0], mem_address[15:0],
//            mem_wdata[15:0] in; mem_resp, mem_rdata[15:0] out.
// Mem side : pmem_read, pmem_write, pmem_address[15:0], pmem_wdata[127:0]
//            out; pmem_rdata[127:0], pmem_resp in.
// Optional : LC3B_CACHE_STATS_EN adds saturating hit_count/miss_count.
// Reset    : rst_n asynchronous, active-low; clears state and valid/dirty.
module lc3b_cache
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef LC3B_CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  lc3b_cache_state  state, state_next;

  lc3b_cache_tag    req_tag;
  lc3b_cache_index  idx;
  lc3b_cache_offset off;
  logic             addr_unused;

  assign req_tag     = mem_address[15:7];
  assign idx         = mem_address[6:4];
  assign off         = mem_address[3:1];
  assign addr_unused = mem_address[0];

  logic             valid_r, dirty_r;
  lc3b_cache_tag    tag_r;
  lc3b_cache_line   line_r;

  logic             valid_we, valid_wd;
  logic             dirty_we, dirty_wd;
  logic             tag_we;
  logic             data_we;
  lc3b_cache_line   data_wd;

  cache_array #(.WIDTH(1), .ASYNC_RST(1'b1)) u_valid (
    .clk(clk), .rst_n(rst_n), .we(valid_we), .index(idx),
    .wdata(valid_wd), .rdata(valid_r)
  );
  cache_array #(.WIDTH(1), .ASYNC_RST(1'b1)) u_dirty (
    .clk(clk), .rst_n(rst_n), .we(dirty_we), .index(idx),
    .wdata(dirty_wd), .rdata(dirty_r)
  );
  cache_array #(.WIDTH(9), .ASYNC_RST(1'b0)) u_tag (
    .clk(clk), .rst_n(rst_n), .we(tag_we), .index(idx),
    .wdata(req_tag), .rdata(tag_r)
  );
  cache_array #(.WIDTH(128), .ASYNC_RST(1'b0)) u_data (
    .clk(clk), .rst_n(rst_n), .we(data_we), .index(idx),
    .wdata(data_wd), .rdata(line_r)
  );

  logic           req, hit;
  lc3b_word       word_r;
  lc3b_cache_line merged;

  assign req    = mem_read | mem_write;
  assign hit    = valid_r && (tag_r == req_tag);
  assign word_r = line_r[{off, 4'b0000} +: 16];
  assign merged = merge_word(line_r, off, mem_wdata, mem_byte_enable);

  logic           hit_start, miss_start, read_latch;

  // Miss-time snapshot of both line addresses and the victim line, so the
  // pmem outputs depend only on registered state.
  logic [15:0]    fill_addr, wb_addr;
  lc3b_cache_line wb_line;

  always_comb begin
    state_next = state;
    valid_we   = 1'b0;
    valid_wd   = 1'b0;
    dirty_we   = 1'b0;
    dirty_wd   = 1'b0;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_wd    = line_r;
    hit_start  = 1'b0;
    miss_start = 1'b0;
    read_latch = 1'b0;
    case (state)
      CACHE_IDLE: begin
        if (req) begin
          if (hit) begin
            state_next = CACHE_RESP;
            hit_start  = 1'b1;
            // Simultaneous read+write is handled as a write.
            if (mem_write) begin
              data_we = 1'b1;
              data_wd = merged;
              if (|mem_byte_enable) begin
                dirty_we = 1'b1;
                dirty_wd = 1'b1;
              end
            end else begin
              read_latch = 1'b1;
            end
          end else begin
            miss_start = 1'b1;
            state_next = (valid_r && dirty_r) ? CACHE_WRITEBACK : CACHE_FILL;
          end
        end
      end
      CACHE_RESP: state_next = CACHE_IDLE;
      CACHE_WRITEBACK: begin
        if (pmem_resp) begin
          dirty_we   = 1'b1;
          dirty_wd   = 1'b0;
          state_next = CACHE_FILL;
        end
      end
      CACHE_FILL: begin
        if (pmem_resp) begin
          valid_we   = 1'b1;
          valid_wd   = 1'b1;
          dirty_we   = 1'b1;
          dirty_wd   = 1'b0;
          tag_we     = 1'b1;
          data_we    = 1'b1;
          data_wd    = pmem_rdata;
          state_next = CACHE_IDLE;
        end
      end
      default: state_next = CACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CACHE_IDLE;
      mem_rdata <= '0;
      fill_addr <= '0;
      wb_addr   <= '0;
      wb_line   <= '0;
    end else begin
      state <= state_next;
      if (read_latch) mem_rdata <= word_r;
      if (miss_start) begin
        fill_addr <= {req_tag, idx, 4'b0000};
        wb_addr   <= {tag_r, idx, 4'b0000};
        wb_line   <= line_r;
      end
    end
  end

  assign mem_resp     = (state == CACHE_RESP);
  assign pmem_read    = (state == CACHE_FILL);
  assign pmem_write   = (state == CACHE_WRITEBACK);
  assign pmem_address = (state == CACHE_FILL)      ? fill_addr :
                        (state == CACHE_WRITEBACK) ? wb_addr   : '0;
  assign pmem_wdata   = (state == CACHE_WRITEBACK) ? wb_line   : '0;

`ifdef LC3B_CACHE_STATS_EN
  // 'refilled' marks that the next IDLE->RESP is the post-fill re-check,
  // which must not be counted as a hit.
  logic refilled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      refilled   <= 1'b0;
    end else begin
      if (state == CACHE_FILL && pmem_resp) refilled <= 1'b1;
      else if (hit_start)                  refilled <= 1'b0;
      if (hit_start && !refilled && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (miss_start && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_cache.sv
module tb_lc3b_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef LC3B_CACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  lc3b_cache dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef LC3B_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Physical memory (line granular) and the flat word-level view the CPU
  // should observe through a transparent cache.
  logic [127:0] phys    [4096];
  logic [15:0]  ref_mem [32768];

  // Cache occupancy model: which line each set holds and whether it is dirty.
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [8:0]   m_tag   [8];
  int           exp_hits = 0, exp_misses = 0;

  // Physical memory responder.
  int           lat = 3;
  bit           busy = 1'b0;
  int           cnt = 0;
  int           n_pr = 0, n_pw = 0;
  logic [15:0]  pr_addr, pw_addr;
  logic [127:0] pw_data;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      check("pmem_exclusive", {127'b0, pmem_read & pmem_write}, 128'b0);
      if (!(pmem_read || pmem_write)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = lat - 1;
        end
        if (cnt == 0) begin
          if (pmem_write) begin
            phys[pmem_address[15:4]] = pmem_wdata;
            pw_addr = pmem_address;
            pw_data = pmem_wdata;
            n_pw++;
          end else begin
            pmem_rdata = phys[pmem_address[15:4]];
            pr_addr = pmem_address;
            n_pr++;
          end
          pmem_resp = 1'b1;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [1:0] be,
                     input logic [15:0] addr, input logic [15:0] wdata,
                     output logic [15:0] rdata, output int cyc,
                     output int pr, output int pw);
    int pr0, pw0;
    pr0 = n_pr;
    pw0 = n_pw;
    @(negedge clk);
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wdata;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 200);
    if (!mem_resp) check("resp_timeout", 128'd0, 128'd1);
    rdata = mem_rdata;
    pr = n_pr - pr0;
    pw = n_pw - pw0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  function automatic logic [127:0] ref_line(input logic [8:0] tg, input logic [2:0] ix);
    logic [127:0] l;
    logic [2:0]   wv;
    for (int w = 0; w < 8; w++) begin
      wv = 3'(w);
      l[16*w +: 16] = ref_mem[{tg, ix, wv}];
    end
    return l;
  endfunction

  // Checks one completed request against the model, then updates the model.
  task automatic model_step(input logic wr, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rdata, input int cyc,
                            input int pr, input int pw);
    logic [2:0] ix;
    logic [8:0] tg;
    bit         hit, dvict;
    int         exp_cyc;
    ix    = addr[6:4];
    tg    = addr[15:7];
    hit   = m_valid[ix] && (m_tag[ix] == tg);
    dvict = !hit && m_valid[ix] && m_dirty[ix];
    exp_cyc = hit ? 1 : (dvict ? 2*lat + 2 : lat + 2);
    check("latency", 128'(cyc), 128'(exp_cyc));
    check("fill_count", 128'(pr), hit ? 128'd0 : 128'd1);
    check("wb_count", 128'(pw), dvict ? 128'd1 : 128'd0);
    if (!hit) check("fill_addr", 128'(pr_addr), 128'({tg, ix, 4'b0}));
    if (dvict) begin
      check("wb_addr", 128'(pw_addr), 128'({m_tag[ix], ix, 4'b0}));
      check("wb_data", pw_data, ref_line(m_tag[ix], ix));
    end
    if (!wr) check("rdata", 128'(rdata), 128'(ref_mem[addr[15:1]]));
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_dirty[ix] = 1'b0;
    end
    if (wr) begin
      if (be[0]) ref_mem[addr[15:1]][7:0]  = wdata[7:0];
      if (be[1]) ref_mem[addr[15:1]][15:8] = wdata[15:8];
      if (|be) m_dirty[ix] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
    // Dirty lines are dropped by reset; the CPU view reverts to memory.
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++)
        ref_mem[l*8 + w] = phys[l][16*w +: 16];
  endtask

  typedef struct {
    logic        rd, wr;
    logic [1:0]  be;
    logic [15:0] addr, wdata;
    logic        chk_rd;
    logic [15:0] exp_rdata;
    int          exp_pr, exp_pw;
    logic [15:0] exp_pr_addr, exp_pw_addr;
  } vec_t;

  vec_t        tbl [5];
  logic [15:0] rdata;
  int          cyc, pr, pw;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++)
        phys[l][16*w +: 16] = 16'(l*16 + w*2) ^ 16'h3C3C;
    phys[12'h012][31:16] = 16'hBEEF;

    tbl[0] = '{1'b1, 1'b0, 2'b11, 16'h0122, 16'h0000, 1'b1, 16'hBEEF, 1, 0, 16'h0120, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 2'b11, 16'h0124, 16'h0000, 1'b1, 16'h3D18, 0, 0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 2'b10, 16'h0123, 16'h5A00, 1'b0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 2'b11, 16'h0122, 16'h0000, 1'b1, 16'h5AEF, 0, 0, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 2'b11, 16'h0922, 16'h0000, 1'b1, 16'h351E, 1, 1, 16'h0920, 16'h0120};

    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = '0; mem_wdata = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mem_resp", 128'(mem_resp), 128'd0);
    check("rst_mem_rdata", 128'(mem_rdata), 128'd0);
    check("rst_pmem_rw", 128'({pmem_read, pmem_write}), 128'd0);
    check("rst_pmem_addr", 128'(pmem_address), 128'd0);
`ifdef LC3B_CACHE_STATS_EN
    check("rst_counts", 128'({hit_count, miss_count}), 128'd0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lat = 3;
    for (int i = 0; i < 5; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].be, tbl[i].addr, tbl[i].wdata, rdata, cyc, pr, pw);
      if (tbl[i].chk_rd) check("tbl_rdata", 128'(rdata), 128'(tbl[i].exp_rdata));
      check("tbl_fills", 128'(pr), 128'(tbl[i].exp_pr));
      check("tbl_wbs", 128'(pw), 128'(tbl[i].exp_pw));
      if (tbl[i].exp_pr != 0) check("tbl_fill_addr", 128'(pr_addr), 128'(tbl[i].exp_pr_addr));
      if (tbl[i].exp_pw != 0) check("tbl_wb_addr", 128'(pw_addr), 128'(tbl[i].exp_pw_addr));
      model_step(tbl[i].wr, tbl[i].be, tbl[i].addr, tbl[i].wdata, rdata, cyc, pr, pw);
    end
    check("tbl_wb_word1", 128'(pw_data[31:16]), 128'h5AEF);
`ifdef LC3B_CACHE_STATS_EN
    check("stats_hits", 128'(hit_count), 128'(exp_hits));
    check("stats_misses", 128'(miss_count), 128'(exp_misses));
`endif

    // Reset while a fill is outstanding.
    lat = 10;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0344;
    repeat (3) @(negedge clk);
    check("fill_pending", 128'(pmem_read), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_pmem_read", 128'(pmem_read), 128'd0);
    check("rst_drops_pmem_addr", 128'(pmem_address), 128'd0);
    check("rst_no_resp", 128'(mem_resp), 128'd0);
    mem_read = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 3;
    txn(1'b1, 1'b0, 2'b11, 16'h0344, 16'h0, rdata, cyc, pr, pw);
    check("post_rst_miss", 128'(pr), 128'd1);
    model_step(1'b0, 2'b11, 16'h0344, 16'h0, rdata, cyc, pr, pw);
    txn(1'b1, 1'b0, 2'b11, 16'h0922, 16'h0, rdata, cyc, pr, pw);
    model_step(1'b0, 2'b11, 16'h0922, 16'h0, rdata, cyc, pr, pw);

    // Random traffic over a few conflicting tags per set.
    for (int i = 0; i < 300; i++) begin
      logic [8:0]  tg;
      logic [15:0] a, wd;
      logic [1:0]  be;
      logic        rd, wr;
      int          kind;
      case ($urandom_range(0, 3))
        0: tg = 9'h000;
        1: tg = 9'h012;
        2: tg = 9'h1FF;
        default: tg = 9'h0A5;
      endcase
      a    = {tg, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      wd   = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 3);
      rd   = (kind <= 1) || (kind == 3);
      wr   = (kind >= 2);
      lat  = $urandom_range(1, 4);
      txn(rd, wr, be, a, wd, rdata, cyc, pr, pw);
      model_step(wr, be, a, wd, rdata, cyc, pr, pw);
    end
`ifdef LC3B_CACHE_STATS_EN
    check("stats_hits_final", 128'(hit_count), 128'(exp_hits));
    check("stats_misses_final", 128'(miss_count), 128'(exp_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
